audio_dac_serializer: RTL

Transmit half of the audio CODEC path: accepts stereo sample pairs from the filter stage over the `write` / `write_ready` handshake, buffers them, and shifts them out on `AUD_DACDAT` in left-justified format. Framing is taken from `AUD_BCLK` and `AUD_DACLRCK`, which the CODEC drives as bus master. It runs entirely on `CLOCK_50` and oversamples the asynchronous CODEC clocks. It is the mirror of the ADC deserializer in the codec interface.

---
 rtl/audio_dac_serializer_pkg.sv | 18 +
 rtl/audio_dac_serializer_fifo.sv | 74 +++++++
 rtl/audio_dac_serializer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/audio_dac_serializer_pkg.sv
// Shared types for the audio CODEC DAC path: sample width, serializer FSM states, stereo pair layout.
// Pure declarations: no latency and no backpressure of its own.
package audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } dac_state_e;

  typedef struct packed {
    logic [AUDIO_DATA_WIDTH-1:0] left;
    logic [AUDIO_DATA_WIDTH-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/audio_dac_serializer_fifo.sv
// Generic synchronous FIFO with registered count; pop data is the combinational head entry.
// Push is dropped while full and pop is ignored while empty, so a simultaneous push/pop never corrupts an entry.
module sample_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_vld,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sample_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign push_ok = push_vld & ~full;
  assign pop_ok  = pop_vld & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two; full/empty come only from the count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified stereo DAC serializer slaved to CODEC BCLK/LRCK, oversampled on CLOCK_50; AUD_DACDAT lags a pin BCLK fall by 4 cycles.
// write_ready drops when the pair FIFO is full; an empty FIFO at frame start sends silence and pulses underflow.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  underflow
);

  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [2:0]            bclk_sync_q, bclk_sync_d;
  logic [1:0]            lrck_sync_q, lrck_sync_d;
  logic                  lrck_prev_q, lrck_prev_d;
  logic                  lrck_primed_q, lrck_primed_d;
  dac_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  dacdat_q, dacdat_d;

  logic                  bclk_fall;
  logic                  lrck_now;
  logic                  frame_start;
  logic                  right_start;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [PAIR_W-1:0]     fifo_push_dat;
  logic [PAIR_W-1:0]     fifo_pop_dat;

  assign write_ready   = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push     = write & ~fifo_full;
  assign fifo_push_dat = {writedata_left, writedata_right};
  assign fifo_pop      = frame_start & ~fifo_empty;
  assign underflow     = frame_start & fifo_empty;
  assign AUD_DACDAT    = dacdat_q;

  sample_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (reset_n),
    .push_vld (fifo_push),
    .push_dat (fifo_push_dat),
    .pop_vld  (fifo_pop),
    .pop_dat  (fifo_pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The first BCLK fall after reset only records LRCK, so a reset released mid-frame cannot fake a frame start.
  always_comb begin
    bclk_sync_d   = {bclk_sync_q[1:0], AUD_BCLK};
    lrck_sync_d   = {lrck_sync_q[0], AUD_DACLRCK};
    bclk_fall     = bclk_sync_q[2] & ~bclk_sync_q[1];
    lrck_now      = lrck_sync_q[1];
    lrck_prev_d   = bclk_fall ? lrck_now : lrck_prev_q;
    lrck_primed_d = lrck_primed_q | bclk_fall;
    frame_start   = bclk_fall & lrck_primed_q & lrck_now & ~lrck_prev_q;
    right_start   = bclk_fall & lrck_primed_q & ~lrck_now & lrck_prev_q;
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    hold_d   = hold_q;
    dacdat_d = (state_q != IDLE) & shift_q[DATA_WIDTH-1];

    case (state_q)
      IDLE:    if (frame_start) state_d = LEFT;
      LEFT:    if (right_start) state_d = RIGHT;
      RIGHT:   if (frame_start) state_d = LEFT;
      default: state_d = IDLE;
    endcase

    // A new LRCK edge always reloads, dropping whatever LSBs a short channel period left unsent.
    if (frame_start) begin
      if (fifo_empty) begin
        shift_d = '0;
        hold_d  = '0;
      end else begin
        shift_d = fifo_pop_dat[PAIR_W-1 -: DATA_WIDTH];
        hold_d  = fifo_pop_dat[DATA_WIDTH-1:0];
      end
    end else if (right_start && state_q == LEFT) begin
      shift_d = hold_q;
    end else if (bclk_fall && state_q != IDLE) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q   <= '0;
      lrck_sync_q   <= '0;
      lrck_prev_q   <= 1'b0;
      lrck_primed_q <= 1'b0;
    end else begin
      bclk_sync_q   <= bclk_sync_d;
      lrck_sync_q   <= lrck_sync_d;
      lrck_prev_q   <= lrck_prev_d;
      lrck_primed_q <= lrck_primed_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      hold_q   <= '0;
      dacdat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      dacdat_q <= dacdat_d;
    end
  end

  underflow_single_cycle: assert property (
    @(posedge CLOCK_50) disable iff (!reset_n) underflow |=> !underflow
  );

endmodule
